// File: rtl/bcd2bin16.sv
// Sequential 5-digit packed-BCD to 16-bit binary converter.
// One acc*10+digit step per clock, most significant digit first; flags overflow and non-decimal digits.
module bcd2bin16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [19:0] bcd_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [15:0] bin_o,
    output logic        ovf_o,
    output logic        inv_o
);
    typedef enum logic {IDLE, CONV} state_t;

    state_t      state_q;
    logic [19:0] shreg_q;
    logic [15:0] acc_q;
    logic        ovf_s_q, inv_s_q;
    logic [2:0]  cnt_q;
    logic        ready_q, done_q, ovf_q, inv_q;
    logic [15:0] bin_q;

    logic [3:0]  dig;
    logic [19:0] next_d;
    logic        step_ovf, step_inv;

    // 20-bit sum keeps the true value of acc*10+d so the overflow compare sees it untruncated.
    always_comb begin
        dig      = shreg_q[19:16];
        next_d   = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0} + {16'h0000, dig};
        step_ovf = |next_d[19:16];
        step_inv = (dig > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            ovf_s_q <= 1'b0;
            inv_s_q <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        shreg_q <= bcd_i;
                        acc_q   <= '0;
                        ovf_s_q <= 1'b0;
                        inv_s_q <= 1'b0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    acc_q   <= next_d[15:0];
                    ovf_s_q <= ovf_s_q | step_ovf;
                    inv_s_q <= inv_s_q | step_inv;
                    shreg_q <= {shreg_q[15:0], 4'h0};
                    cnt_q   <= cnt_q + 3'd1;
                    if (cnt_q == 3'd4) begin
                        bin_q   <= next_d[15:0];
                        ovf_q   <= ovf_s_q | step_ovf;
                        inv_q   <= inv_s_q | step_inv;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign bin_o   = bin_q;
    assign ovf_o   = ovf_q;
    assign inv_o   = inv_q;
endmodule
